stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Handshake front end for the `stack` block: converts a valid/ready push stream and a valid/ready pop-request stream into the stack's single-cycle `push`/`pop` strobes. It tracks occupancy, blocks overflow and underflow, and returns popped words through a registered valid/ready response port. It sits directly upstream of `stack`, and its `stk_*` ports wire one-to-one to that instance.

## Interface
- `WIDTH`, 18, data word width; must match the attached stack.
- `SIZE`, 1, log2 of stack depth; depth D = 2**SIZE; must match the attached stack.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push_valid`  in  1  push request.
- `push_ready`  out  1  push accepted this cycle when high with `push_valid`.
- `push_data`  in  WIDTH  word to push.
- `pop_valid`  in  1  pop request.
- `pop_ready`  out  1  pop accepted this cycle when high with `pop_valid`.
- `rsp_valid`  out  1  popped word available.
- `rsp_ready`  in  1  consumer takes `rsp_data`.
- `rsp_data`  out  WIDTH  popped word.
- `stk_push`  out  1  to stack `push`.
- `stk_pop`  out  1  to stack `pop`.
- `stk_din`  out  WIDTH  to stack `data_in`; equals `push_data`.
- `stk_dout`  in  WIDTH  from stack `data_out`.
- `count`  out  SIZE+1  entries held, 0..D.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == D`.
- `hwm`  out  SIZE+1  high-water mark; present only with `STACK_CTRL_HWM_EN`.

## Operation
- Stack contract: `stk_dout` shows the current top entry in every cycle after the clock edge of the last strobe. `stk_push` and `stk_pop` are never both high in the same cycle.
- `pop_ok = !empty && (!rsp_valid || rsp_ready)`.
- `pop_ready = pop_ok`.
- `stk_pop = pop_valid && pop_ok`.
- `push_ready = !full && !stk_pop`.
- `stk_push = push_valid && push_ready`.
- Simultaneous push and pop: the pop wins and the push stalls for that cycle. This gives strict LIFO order with respect to already-accepted data.
- On a `stk_pop` edge:
  - `rsp_data <= stk_dout`.
  - `rsp_valid <= 1`.
  - `count <= count - 1`.
- On a `stk_push` edge: `count <= count + 1`.
- Response register clear: when `rsp_valid && rsp_ready` and there is no new pop, `rsp_valid <= 0`. `rsp_data` holds its last value.
- While `rsp_valid && !rsp_ready`: `rsp_data` and `rsp_valid` are stable, pops are blocked, and pushes continue.
- `count` never wraps: full blocks increment and empty blocks decrement by construction.
- `push_ready` and `pop_ready` are combinational from state and inputs. There is no combinational path from `push_valid` to any ready signal.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - `count = 0`, `empty = 1`, `full = 0`.
  - `rsp_valid = 0`, `rsp_data = 0`, `hwm = 0`.
- While `reset` is low: `push_ready`, `pop_ready`, `stk_push` and `stk_pop` are forced to 0.
- Reset mid-operation drops all entries and any pending response. The stack itself shares this reset.
- Push latency: the word is in the stack at the accepting edge. A pop in the next cycle returns it.
- Pop latency: `rsp_valid` rises 1 cycle after pop acceptance.
- Throughput: 1 pop per cycle while `rsp_ready` is held high; 1 push per cycle when not full and not popping.
- `empty` and `full` update on the same edge as `count`.

## Configuration
- `STACK_CTRL_HWM_EN` defined:
  - `hwm` port exists.
  - At each edge, `hwm <= max(hwm, next count)`.
  - `hwm` is cleared only by reset.
- `STACK_CTRL_HWM_EN` undefined: no `hwm` port and no `hwm` register. All other behaviour is identical.

## Test plan
- Reset with SIZE=1: `count=0`, `empty=1`, `full=0`, `rsp_valid=0`, both readies 0 while reset is low.
- Push `0x15555`, `0x2AAAA`, `0x04444` back to back:
  - The first two are accepted.
  - Then `full=1`, `push_ready=0`, and the third is held until space frees.
- With stack full and `rsp_ready=1`, pop twice: `rsp_data` is `0x2AAAA` then `0x15555` on consecutive cycles, then `empty=1` and `pop_ready=0`.
- `push_valid` and `pop_valid` together with count=1:
  - The pop is taken and returns the stored word.
  - The push is accepted the next cycle.
  - `count` goes 1→0→1.
- Response backpressure, pop with `rsp_ready=0` for 3 cycles:
  - `rsp_data` is stable.
  - A second pop is not accepted.
  - A push is accepted meanwhile.
- Reset asserted with count=2 and `rsp_valid=1`: all outputs return to reset values immediately. With `STACK_CTRL_HWM_EN`, `hwm` reads 2 before the reset and 0 after it.

Source files
------------

// File: rtl/stack_ctrl.sv
// stack_ctrl: valid/ready front end for the stack block.
// Turns a push stream and a pop-request stream into single-cycle stk_push/stk_pop
// strobes, tracks occupancy, blocks overflow/underflow, and returns popped words
// through a registered valid/ready response port.
// Optional feature macro: STACK_CTRL_HWM_EN adds the hwm (high-water mark) port.
module stack_ctrl #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned SIZE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_valid,
  output logic             pop_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic [SIZE:0]    count,
  output logic             empty,
  output logic             full
`ifdef STACK_CTRL_HWM_EN
  ,
  output logic [SIZE:0]    hwm
`endif
);

  localparam int unsigned CW    = SIZE + 1;
  localparam int unsigned DEPTH = 1 << SIZE;
  localparam logic [SIZE:0] DEPTH_C = CW'(DEPTH);

  logic          pop_ok;
  logic [SIZE:0] count_nxt;

  // Handshake decode: pop has priority over push; all strobes held low in reset.
  always_comb begin
    pop_ok     = reset && !empty && (!rsp_valid || rsp_ready);
    pop_ready  = pop_ok;
    stk_pop    = pop_valid && pop_ok;
    push_ready = reset && !full && !stk_pop;
    stk_push   = push_valid && push_ready;
    stk_din    = push_data;
  end

  // Next occupancy; the strobes are mutually exclusive so at most one applies.
  always_comb begin
    count_nxt = count;
    if (stk_push) begin
      count_nxt = count + CW'(1);
    end else if (stk_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Occupancy and status flags, all updated on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == DEPTH_C);
    end
  end

  // Response register: load on pop, clear when consumed without a new pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (stk_pop) begin
      rsp_valid <= 1'b1;
      rsp_data  <= stk_dout;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef STACK_CTRL_HWM_EN
  // High-water mark of occupancy; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hwm <= '0;
    end else if (count_nxt > hwm) begin
      hwm <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl with a behavioural stack attached to the stk_* ports.
// Responses are checked by a scoreboard queue filled by the stimulus process.
module tb_stack_ctrl;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned SIZE  = 1;
  localparam int unsigned DEPTH = 1 << SIZE;

  logic             clk;
  logic             reset;
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_data;
  logic             pop_valid;
  logic             pop_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;
  logic [SIZE:0]    count;
  logic             empty;
  logic             full;
`ifdef STACK_CTRL_HWM_EN
  logic [SIZE:0]    hwm;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .stk_push   (stk_push),
    .stk_pop    (stk_pop),
    .stk_din    (stk_din),
    .stk_dout   (stk_dout),
    .count      (count),
    .empty      (empty),
    .full       (full)
`ifdef STACK_CTRL_HWM_EN
    ,
    .hwm        (hwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: top entry visible after the strobe edge.
  logic [WIDTH-1:0] mem [DEPTH];
  int sp;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= 0;
    end else if (stk_push && sp < int'(DEPTH)) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end
  always_comb stk_dout = (sp > 0) ? mem[sp-1] : '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: compare each handshaken response with the scoreboard.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got 0x%0h, expected no response at %0t", rsp_data, $time);
      end else begin
        check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Stack contract: never push and pop together.
  always @(negedge clk) begin
    if (stk_push && stk_pop) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap: got push=1 pop=1, expected at most one at %0t", $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; push_valid = 1'b1; push_data = 18'h15555;
    pop_valid = 1'b1; rsp_ready = 1'b1;
    tick(); tick();
    // Reset state, readies forced low despite requests
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd0);
    check("rst_pop_ready", 32'(pop_ready), 32'd0);
    push_valid = 1'b0; pop_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Back-to-back pushes into a depth-2 stack
    push_valid = 1'b1; push_data = 18'h15555; #1;
    check("push1_ready", 32'(push_ready), 32'd1);
    tick();
    push_data = 18'h2AAAA; #1;
    check("push2_ready", 32'(push_ready), 32'd1);
    check("count_1", 32'(count), 32'd1);
    tick();
    push_data = 18'h04444; #1;
    check("full_set", 32'(full), 32'd1);
    check("count_2", 32'(count), 32'd2);
    check("push3_held", 32'(push_ready), 32'd0);
    tick();
    check("push3_still_held", 32'(push_ready), 32'd0);
    check("count_stays_2", 32'(count), 32'd2);
    push_valid = 1'b0;

    // Two pops at full rate, LIFO order
    rsp_ready = 1'b1; pop_valid = 1'b1; #1;
    check("pop1_ready", 32'(pop_ready), 32'd1);
    exp_q.push_back(18'h2AAAA);
    tick();
    check("pop2_ready", 32'(pop_ready), 32'd1);
    exp_q.push_back(18'h15555);
    tick();
    check("drained_count", 32'(count), 32'd0);
    check("drained_empty", 32'(empty), 32'd1);
    check("drained_pop_ready", 32'(pop_ready), 32'd0);
    pop_valid = 1'b0;
    tick();

    // Simultaneous push and pop at count=1: pop first, push next cycle
    push_valid = 1'b1; push_data = 18'h04444;
    tick();
    push_valid = 1'b0; #1;
    check("sim_pre_count", 32'(count), 32'd1);
    push_valid = 1'b1; push_data = 18'h0AAAA; pop_valid = 1'b1; #1;
    check("sim_pop_ready", 32'(pop_ready), 32'd1);
    check("sim_push_stalled", 32'(push_ready), 32'd0);
    exp_q.push_back(18'h04444);
    tick();
    check("sim_count_0", 32'(count), 32'd0);
    check("sim_push_ready", 32'(push_ready), 32'd1);
    tick();
    check("sim_count_1", 32'(count), 32'd1);
    push_valid = 1'b0; pop_valid = 1'b0;
    tick();

    // Response backpressure
    push_valid = 1'b1; push_data = 18'h00123;
    tick();
    push_valid = 1'b0; rsp_ready = 1'b0; pop_valid = 1'b1; #1;
    check("bp_count_2", 32'(count), 32'd2);
    check("bp_pop_ready", 32'(pop_ready), 32'd1);
    exp_q.push_back(18'h00123);
    tick();
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rsp_data", 32'(rsp_data), 32'(18'h00123));
    check("bp_pop_blocked", 32'(pop_ready), 32'd0);
    check("bp_push_ready", 32'(push_ready), 32'd1);
    push_valid = 1'b1; push_data = 18'h00777;
    tick();
    push_valid = 1'b0; #1;
    check("bp_push_count", 32'(count), 32'd2);
    check("bp_rsp_stable1", 32'(rsp_data), 32'(18'h00123));
    tick();
    check("bp_rsp_stable2", 32'(rsp_data), 32'(18'h00123));
    check("bp_rsp_valid2", 32'(rsp_valid), 32'd1);
    check("bp_no_second_pop", 32'(count), 32'd2);
`ifdef STACK_CTRL_HWM_EN
    check("hwm_before_reset", 32'(hwm), 32'd2);
`endif

    // Asynchronous reset mid-operation
    reset = 1'b0; #1;
    exp_q.delete();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    check("mid_rst_pop_ready", 32'(pop_ready), 32'd0);
    check("mid_rst_push_ready", 32'(push_ready), 32'd0);
`ifdef STACK_CTRL_HWM_EN
    check("hwm_after_reset", 32'(hwm), 32'd0);
`endif
    pop_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();

    // Post-reset round trip
    push_valid = 1'b1; push_data = 18'h3FFFF;
    tick();
    push_valid = 1'b0; pop_valid = 1'b1;
    exp_q.push_back(18'h3FFFF);
    tick();
    pop_valid = 1'b0;
    tick(); tick();
    check("final_count", 32'(count), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
